card_dealer: RTL

Random-number consumer for the blackjack datapath. It takes the free-running 32-bit `randnum` from the `lfsr` and turns deal requests into unique card draws from a single 52-card deck, so no card repeats until the deck is shuffled. It sits between the `lfsr` and the game-control FSM, which issues `deal_req` and `shuffle` and consumes `card_valid`.

---
 rtl/card_pkg.sv | 23 ++
 rtl/card_decode.sv | 31 +++
 rtl/card_dealer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer datapath.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;

    typedef logic [5:0] card_idx_t;
    typedef logic [1:0] suit_t;
    typedef logic [3:0] rank_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_CLEAR
    } state_t;

    // Fold a 6-bit random value (0..63) into the deck range 0..51.
    // Values 52..63 map to 0..11, a small bias that is accepted.
    function automatic card_idx_t reduce_rand(input logic [5:0] r);
        return (r >= 6'(DECK_SIZE)) ? r - 6'(DECK_SIZE) : r;
    endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational decode of a card index into suit, rank and blackjack points.
module card_decode
    import card_pkg::*;
(
    input  card_idx_t idx_i,
    output suit_t     suit_o,
    output rank_t     rank_o,
    output rank_t     points_o
);

    card_idx_t base;

    // Suit by range compare instead of a divider; rank is the offset within the suit.
    always_comb begin
        suit_o = 2'd0;
        base   = 6'd0;
        if (idx_i >= 6'(3 * RANKS)) begin
            suit_o = 2'd3;
            base   = 6'(3 * RANKS);
        end else if (idx_i >= 6'(2 * RANKS)) begin
            suit_o = 2'd2;
            base   = 6'(2 * RANKS);
        end else if (idx_i >= 6'(RANKS)) begin
            suit_o = 2'd1;
            base   = 6'(RANKS);
        end
        rank_o   = 4'(idx_i - base + 6'd1);
        points_o = (rank_o > 4'd10) ? 4'd10 : rank_o;
    end

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from a single 52-card deck using a used-card mask and
// a linear probe that walks forward (with wrap) from a random start index.
module card_dealer
    import card_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] randnum,
    input  logic        deal_req,
    input  logic        shuffle,
    output logic        card_valid,
    output card_idx_t   card_idx,
    output suit_t       suit,
    output rank_t       rank,
    output rank_t       points,
    output logic [5:0]  remaining,
    output logic        busy,
    output logic        deal_err
);

    state_t                 state_q, state_d;
    logic [DECK_SIZE-1:0]   used_q, used_d;
    card_idx_t              cand_q, cand_d;
    logic [5:0]             remaining_q, remaining_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    card_idx_t              idx_q, idx_d;
    suit_t                  suit_q, suit_d;
    rank_t                  rank_q, rank_d;
    rank_t                  points_q, points_d;

    suit_t                  dec_suit;
    rank_t                  dec_rank;
    rank_t                  dec_points;

    // Only the low six bits of the random word drive the start index.
    logic                   unused_rand;
    assign unused_rand = ^randnum[31:6];

    card_decode u_decode (
        .idx_i    (cand_q),
        .suit_o   (dec_suit),
        .rank_o   (dec_rank),
        .points_o (dec_points)
    );

    // Next-state, mask update and registered-output values.
    always_comb begin
        state_d     = state_q;
        used_d      = used_q;
        cand_d      = cand_q;
        remaining_d = remaining_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        idx_d       = idx_q;
        suit_d      = suit_q;
        rank_d      = rank_q;
        points_d    = points_q;

        case (state_q)
            ST_IDLE: begin
                if (shuffle) begin
                    state_d = ST_CLEAR;
                end else if (deal_req) begin
                    if (remaining_q == 6'd0) begin
                        err_d = 1'b1;
                    end else begin
                        cand_d  = reduce_rand(randnum[5:0]);
                        state_d = ST_PROBE;
                    end
                end
            end
            ST_PROBE: begin
                // A shuffle abandons the search; the mask is wiped by CLEAR.
                if (shuffle) begin
                    state_d = ST_CLEAR;
                end else if (!used_q[cand_q]) begin
                    used_d[cand_q] = 1'b1;
                    remaining_d    = remaining_q - 6'd1;
                    valid_d        = 1'b1;
                    idx_d          = cand_q;
                    suit_d         = dec_suit;
                    rank_d         = dec_rank;
                    points_d       = dec_points;
                    state_d        = ST_IDLE;
                end else begin
                    cand_d = (cand_q == 6'(DECK_SIZE - 1)) ? 6'd0 : cand_q + 6'd1;
                end
            end
            ST_CLEAR: begin
                used_d      = '0;
                remaining_d = 6'(DECK_SIZE);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, mask and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            used_q      <= '0;
            cand_q      <= '0;
            remaining_q <= 6'(DECK_SIZE);
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            suit_q      <= '0;
            rank_q      <= '0;
            points_q    <= '0;
        end else begin
            state_q     <= state_d;
            used_q      <= used_d;
            cand_q      <= cand_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            suit_q      <= suit_d;
            rank_q      <= rank_d;
            points_q    <= points_d;
        end
    end

    assign card_valid = valid_q;
    assign card_idx   = idx_q;
    assign suit       = suit_q;
    assign rank       = rank_q;
    assign points     = points_q;
    assign remaining  = remaining_q;
    assign busy       = busy_q;
    assign deal_err   = err_q;

endmodule
